// File: rtl/cp_drv_if.sv
// Charge-pump request bundle plus the node view: voltage in, current and source resistance out.
`timescale 1ns/1ps
interface cp_drv_if;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned ST_W  = 3;

  logic             en;      // pump enable
  logic             up;      // charge request from PFD
  logic             dn;      // discharge request from PFD
  logic             clr_q;   // synchronous clear of charge and pulse counters
  real              v;       // node voltage reported by the capacitor network
  real              i;       // current driven into the node (A)
  real              r;       // source resistance presented on the node (ohm)
  logic             sat_hi;
  logic             sat_lo;
  logic [ST_W-1:0]  state;
  logic [CNT_W-1:0] up_cnt;
  logic [CNT_W-1:0] dn_cnt;
  real              q_acc;   // net delivered charge (C)

  // Requester / node side
  modport master (
    output en, up, dn, clr_q, v,
    input  i, r, sat_hi, sat_lo, state, up_cnt, dn_cnt, q_acc
  );

  // Charge-pump driver side
  modport slave (
    input  en, up, dn, clr_q, v,
    output i, r, sat_hi, sat_lo, state, up_cnt, dn_cnt, q_acc
  );
endinterface

// File: rtl/cp_drv.sv
// Clocked charge-pump driver: dead-zone filtered UP/DN requests become a
// registered current on the loop-filter node, with compliance saturation
// (hysteretic release) and a delivered-charge accumulator.
`timescale 1ns/1ps
module cp_drv #(
  parameter real         ICP      = 100e-6,
  parameter real         MISMATCH = 0.0,
  parameter real         ROUT     = 1e6,
  parameter int unsigned DZ       = 1,
  parameter real         VMAX     = 1.1,
  parameter real         VMIN     = 0.1,
  parameter real         VHYS     = 0.02
) (
  input  logic     clk,
  input  logic     rst_n,
  cp_drv_if.slave  bus
);

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ST_W   = 3;

  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
  localparam logic [HOLD_W-1:0] DZ_TH    = HOLD_W'(DZ);

  // Current delivered in each pumping state; BOTH leaves only the mismatch residual
  localparam real I_UP   = ICP;
  localparam real I_DN   = -(ICP * (1.0 + MISMATCH));
  localparam real I_BOTH = ICP - ICP * (1.0 + MISMATCH);

  // $realtime is in ns under this file's timescale
  localparam real SEC_PER_UNIT = 1e-9;

  typedef enum logic [ST_W-1:0] {
    IDLE    = 3'd0,
    PUMP_UP = 3'd1,
    PUMP_DN = 3'd2,
    BOTH    = 3'd3,
    SAT     = 3'd4
  } state_t;

  logic [HOLD_W-1:0] up_hold;
  logic [HOLD_W-1:0] dn_hold;
  logic              uq;
  logic              dq;
  logic              uq_q;
  logic              dq_q;

  state_t            state_q;
  state_t            state_n;
  state_t            req_st;
  real               req_i;
  real               iout_q;
  real               iout_n;
  logic              sat_hi_q;
  logic              sat_hi_n;
  logic              sat_lo_q;
  logic              sat_lo_n;

  logic [CNT_W-1:0]  up_cnt_q;
  logic [CNT_W-1:0]  dn_cnt_q;
  real               q_acc_q;
  real               t_prev;
  logic              t_valid;

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] h);
    return (h == HOLD_MAX) ? h : h + HOLD_W'(1);
  endfunction

  // A request qualifies once it has been seen high for DZ earlier consecutive samples
  assign uq = bus.up && (up_hold >= DZ_TH);
  assign dq = bus.dn && (dn_hold >= DZ_TH);

  // Dead-zone run-length counters and qualification history for onset detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_hold <= '0;
      dn_hold <= '0;
      uq_q    <= 1'b0;
      dq_q    <= 1'b0;
    end else begin
      up_hold <= bus.up ? sat_inc(up_hold) : '0;
      dn_hold <= bus.dn ? sat_inc(dn_hold) : '0;
      uq_q    <= uq;
      dq_q    <= dq;
    end
  end

  // Next state, drive current and compliance flags from qualified requests and node voltage
  always_comb begin
    req_st   = IDLE;
    req_i    = 0.0;
    state_n  = IDLE;
    iout_n   = 0.0;
    sat_hi_n = sat_hi_q;
    sat_lo_n = sat_lo_q;

    if (bus.en) begin
      if (uq && dq) begin
        req_st = BOTH;
        req_i  = I_BOTH;
      end else if (uq) begin
        req_st = PUMP_UP;
        req_i  = I_UP;
      end else if (dq) begin
        req_st = PUMP_DN;
        req_i  = I_DN;
      end
    end

    // Flags release only past the hysteresis band, set only when pushing into the rail
    if (sat_hi_q && (bus.v < VMAX - VHYS)) sat_hi_n = 1'b0;
    if (sat_lo_q && (bus.v > VMIN + VHYS)) sat_lo_n = 1'b0;
    if ((bus.v >= VMAX) && (req_i > 0.0))  sat_hi_n = 1'b1;
    if ((bus.v <= VMIN) && (req_i < 0.0))  sat_lo_n = 1'b1;

    // Only current pushing toward an active rail is blocked
    if (((req_i > 0.0) && sat_hi_n) || ((req_i < 0.0) && sat_lo_n)) begin
      state_n = SAT;
      iout_n  = 0.0;
    end else begin
      state_n = req_st;
      iout_n  = req_i;
    end
  end

  // FSM state, registered drive current and saturation flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      iout_q   <= 0.0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      iout_q   <= iout_n;
      sat_hi_q <= sat_hi_n;
      sat_lo_q <= sat_lo_n;
    end
  end

  // Pulse counters and charge integration over the interval ending at this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_cnt_q <= '0;
      dn_cnt_q <= '0;
      q_acc_q  <= 0.0;
      t_prev   <= 0.0;
      t_valid  <= 1'b0;
    end else begin
      t_prev  <= $realtime;
      t_valid <= 1'b1;
      if (bus.clr_q) begin
        up_cnt_q <= '0;
        dn_cnt_q <= '0;
        q_acc_q  <= 0.0;
      end else begin
        if (uq && !uq_q) up_cnt_q <= up_cnt_q + CNT_W'(1);
        if (dq && !dq_q) dn_cnt_q <= dn_cnt_q + CNT_W'(1);
        if (t_valid) q_acc_q <= q_acc_q + iout_q * ($realtime - t_prev) * SEC_PER_UNIT;
      end
    end
  end

  assign bus.i      = iout_q;
  assign bus.r      = ROUT;
  assign bus.state  = state_q;
  assign bus.sat_hi = sat_hi_q;
  assign bus.sat_lo = sat_lo_q;
  assign bus.up_cnt = up_cnt_q;
  assign bus.dn_cnt = dn_cnt_q;
  assign bus.q_acc  = q_acc_q;

endmodule

// File: tb/tb_cp_drv.sv
// Bench for cp_drv: vector table, directed corner sequences and a random run
// against a behavioural model of the pump with an ideal 1pF node capacitor.
`timescale 1ns/1ps
module tb_cp_drv;

  localparam real ICP    = 100e-6;
  localparam real MM     = 0.05;
  localparam real VMAX   = 1.1;
  localparam real VMIN   = 0.1;
  localparam real VHYS   = 0.02;
  localparam int  DZ     = 1;
  localparam real T_S    = 1e-9;
  localparam real C_NODE = 1e-12;

  logic clk = 1'b0;
  logic rst_n;

  cp_drv_if bus ();
  cp_drv_if bus3 ();

  cp_drv #(.ICP(ICP), .MISMATCH(MM), .ROUT(1e6), .DZ(DZ),
           .VMAX(VMAX), .VMIN(VMIN), .VHYS(VHYS))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  cp_drv #(.ICP(ICP), .MISMATCH(0.0), .ROUT(1e6), .DZ(3),
           .VMAX(VMAX), .VMIN(VMIN), .VHYS(VHYS))
    u_dz3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  always #0.5 clk = ~clk;

  int  n_vec = 0;
  int  n_err = 0;
  bit  cap_on = 1'b0;
  bit  up3 = 1'b0;

  // Reference model state
  int  m_urun, m_drun;
  bit  m_uq, m_dq, m_sh, m_sl, m_first;
  int  m_st, m_ucnt, m_dcnt;
  real m_i, m_q;

  typedef struct {
    logic [3:0] ctl;   // {en, up, dn, clr_q}
    int         st;
    int         ucnt;
    int         dcnt;
    real        i;
    real        q;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic [3:0] c, int st, int uc, int dc, real i, real q);
    vec_t r;
    r.ctl = c; r.st = st; r.ucnt = uc; r.dcnt = dc; r.i = i; r.q = q;
    return r;
  endfunction

  task automatic chk_i(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_r(input string nm, input real act, input real exp, input real tol);
    n_vec++;
    if ((act - exp > tol) || (exp - act > tol)) begin
      n_err++;
      $display("FAIL %s: got %g expected %g at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic real qtol(input real q);
    return 1e-22 + 1e-9 * ((q < 0.0) ? -q : q);
  endfunction

  function automatic void m_reset();
    m_urun = 0; m_drun = 0; m_uq = 0; m_dq = 0; m_sh = 0; m_sl = 0;
    m_first = 1; m_st = 0; m_ucnt = 0; m_dcnt = 0; m_i = 0.0; m_q = 0.0;
  endfunction

  // One sampling edge of the pump described from its rules
  function automatic void m_edge(input bit en, input bit up, input bit dn, input bit clr, input real v);
    bit  uq, dq;
    real want;
    int  st;
    uq = up && (m_urun >= DZ);
    dq = dn && (m_drun >= DZ);
    if (clr) begin
      m_q = 0.0; m_ucnt = 0; m_dcnt = 0;
    end else begin
      if (!m_first) m_q = m_q + m_i * T_S;
      if (uq && !m_uq) m_ucnt = (m_ucnt + 1) % 65536;
      if (dq && !m_dq) m_dcnt = (m_dcnt + 1) % 65536;
    end
    m_first = 0;
    m_uq = uq; m_dq = dq;
    m_urun = up ? m_urun + 1 : 0;
    m_drun = dn ? m_drun + 1 : 0;
    want = 0.0; st = 0;
    if (en && uq && dq)  begin want = ICP - ICP * (1.0 + MM); st = 3; end
    else if (en && uq)   begin want = ICP;                    st = 1; end
    else if (en && dq)   begin want = -(ICP * (1.0 + MM));    st = 2; end
    m_sh = (m_sh && !(v < VMAX - VHYS)) || ((v >= VMAX) && (want > 0.0));
    m_sl = (m_sl && !(v > VMIN + VHYS)) || ((v <= VMIN) && (want < 0.0));
    if (((want > 0.0) && m_sh) || ((want < 0.0) && m_sl)) begin want = 0.0; st = 4; end
    m_i = want; m_st = st;
  endfunction

  // Drive inputs (away from edges), take one edge, advance model and node voltage
  task automatic step(input bit e, input bit u, input bit d, input bit c);
    bus.en = e; bus.up = u; bus.dn = d; bus.clr_q = c;
    bus3.up = up3;
    @(posedge clk);
    m_edge(e, u, d, c, bus.v);
    #0.1;
    if (cap_on) bus.v = bus.v + m_i * T_S / C_NODE;
  endtask

  task automatic release_reset();
    bus.en = 0; bus.up = 0; bus.dn = 0; bus.clr_q = 0;
    up3 = 0; bus3.up = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_all(input string tag);
    chk_i({tag, " state"},  int'(bus.state),  m_st);
    chk_r({tag, " iout"},   bus.i,            m_i, 1e-12);
    chk_i({tag, " sat_hi"}, int'(bus.sat_hi), int'(m_sh));
    chk_i({tag, " sat_lo"}, int'(bus.sat_lo), int'(m_sl));
    chk_i({tag, " up_cnt"}, int'(bus.up_cnt), m_ucnt);
    chk_i({tag, " dn_cnt"}, int'(bus.dn_cnt), m_dcnt);
    chk_r({tag, " q_acc"},  bus.q_acc,        m_q, qtol(m_q));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cu, cd;
    // Vectors from reset: DZ=1, MISMATCH=0.05, node mid-rail
    tbl[0]  = mk(4'b1100, 0, 0, 0, 0.0,     0.0);
    tbl[1]  = mk(4'b1100, 1, 1, 0, 1e-4,    0.0);
    tbl[2]  = mk(4'b1100, 1, 1, 0, 1e-4,    1e-13);
    tbl[3]  = mk(4'b1110, 1, 1, 0, 1e-4,    2e-13);
    tbl[4]  = mk(4'b1110, 3, 1, 1, -5e-6,   3e-13);
    tbl[5]  = mk(4'b1010, 2, 1, 1, -1.05e-4, 2.95e-13);
    tbl[6]  = mk(4'b1000, 0, 1, 1, 0.0,     1.9e-13);
    tbl[7]  = mk(4'b1110, 0, 1, 1, 0.0,     1.9e-13);
    tbl[8]  = mk(4'b1110, 3, 2, 2, -5e-6,   1.9e-13);
    tbl[9]  = mk(4'b0110, 0, 2, 2, 0.0,     1.85e-13);
    tbl[10] = mk(4'b0000, 0, 2, 2, 0.0,     1.85e-13);
    tbl[11] = mk(4'b0100, 0, 2, 2, 0.0,     1.85e-13);
    tbl[12] = mk(4'b0100, 0, 3, 2, 0.0,     1.85e-13);
    tbl[13] = mk(4'b1100, 1, 3, 2, 1e-4,    1.85e-13);
    tbl[14] = mk(4'b1101, 1, 0, 0, 1e-4,    0.0);
    tbl[15] = mk(4'b1000, 0, 0, 0, 0.0,     1e-13);

    rst_n = 1'b0;
    m_reset();
    bus.en = 0; bus.up = 0; bus.dn = 0; bus.clr_q = 0; bus.v = 0.6;
    bus3.en = 1; bus3.up = 0; bus3.dn = 0; bus3.clr_q = 0; bus3.v = 0.6;
    #2.2;
    chk_i("rst state",  int'(bus.state),  0);
    chk_r("rst iout",   bus.i,            0.0, 1e-15);
    chk_i("rst sat_hi", int'(bus.sat_hi), 0);
    chk_i("rst sat_lo", int'(bus.sat_lo), 0);
    chk_i("rst up_cnt", int'(bus.up_cnt), 0);
    chk_i("rst dn_cnt", int'(bus.dn_cnt), 0);
    chk_r("rst q_acc",  bus.q_acc,        0.0, 1e-25);
    chk_r("rout",       bus.r,            1e6, 1e-3);
    release_reset();

    // Table vectors
    for (int k = 0; k < 16; k++) begin
      step(tbl[k].ctl[3], tbl[k].ctl[2], tbl[k].ctl[1], tbl[k].ctl[0]);
      chk_i($sformatf("tbl%0d state", k),  int'(bus.state),  tbl[k].st);
      chk_i($sformatf("tbl%0d up_cnt", k), int'(bus.up_cnt), tbl[k].ucnt);
      chk_i($sformatf("tbl%0d dn_cnt", k), int'(bus.dn_cnt), tbl[k].dcnt);
      chk_r($sformatf("tbl%0d iout", k),   bus.i,            tbl[k].i, 1e-12);
      chk_r($sformatf("tbl%0d q_acc", k),  bus.q_acc,        tbl[k].q, qtol(tbl[k].q));
    end

    // Reset in the middle of an UP pump drops current immediately
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk_r("pre-reset iout", bus.i, 1e-4, 1e-12);
    #0.2;
    rst_n = 1'b0;
    m_reset();
    #0.01;
    chk_r("midrst iout",   bus.i,            0.0, 1e-15);
    chk_i("midrst state",  int'(bus.state),  0);
    chk_i("midrst up_cnt", int'(bus.up_cnt), 0);
    chk_i("midrst dn_cnt", int'(bus.dn_cnt), 0);
    chk_r("midrst q_acc",  bus.q_acc,        0.0, 1e-25);
    release_reset();

    // Single 5-cycle UP pulse: qualifies on its second sample
    step(1, 1, 0, 0);
    chk_i("pulse s1 state", int'(bus.state), 0);
    step(1, 1, 0, 0);
    chk_i("pulse s2 state", int'(bus.state), 1);
    chk_r("pulse s2 iout",  bus.i, 1e-4, 1e-12);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk_i("pulse end state",  int'(bus.state),  0);
    chk_i("pulse end up_cnt", int'(bus.up_cnt), 1);
    chk_r("pulse end q_acc",  bus.q_acc, 4e-13, qtol(4e-13));

    // DZ=3: two-cycle pulses never qualify; a fourth consecutive sample does
    for (int p = 0; p < 10; p++) begin
      up3 = 1; step(0, 0, 0, 0); step(0, 0, 0, 0);
      up3 = 0; step(0, 0, 0, 0); step(0, 0, 0, 0);
      chk_r($sformatf("dz3 pulse%0d iout", p), bus3.i, 0.0, 1e-15);
    end
    chk_i("dz3 up_cnt", int'(bus3.up_cnt), 0);
    chk_r("dz3 q_acc",  bus3.q_acc, 0.0, 1e-25);
    up3 = 1;
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk_i("dz3 3rd sample state", int'(bus3.state), 0);
    step(0, 0, 0, 0);
    chk_i("dz3 4th sample state", int'(bus3.state), 1);
    chk_i("dz3 onset up_cnt", int'(bus3.up_cnt), 1);
    up3 = 0;
    step(0, 0, 0, 0);

    // Upper compliance on a 1pF node starting at 1.0V
    bus.v = 1.0;
    cap_on = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 0, 0);
      chk_i("sat climb state", int'(bus.state), m_st);
      if (m_sh) break;
    end
    chk_i("sat_hi set",   int'(bus.sat_hi), 1);
    chk_i("sat_hi state", int'(bus.state),  4);
    chk_r("sat_hi iout",  bus.i, 0.0, 1e-15);
    step(1, 0, 1, 0);
    chk_i("sat dn s1 state", int'(bus.state), 0);
    step(1, 0, 1, 0);
    chk_i("sat dn s2 state",  int'(bus.state),  2);
    chk_i("sat dn s2 sat_hi", int'(bus.sat_hi), 1);
    chk_r("sat dn s2 iout",   bus.i, -1.05e-4, 1e-12);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 1, 0);
      if (!m_sh) break;
    end
    chk_i("sat_hi release", int'(bus.sat_hi), 0);
    chk_i("release state",  int'(bus.state),  2);
    cap_on = 1'b0;
    bus.v = 0.6;
    step(0, 0, 0, 0);

    // Disabled pump: no current, but qualified pulses still counted
    for (int k = 0; k < 20; k++) begin
      int k1;
      k1 = k + 1;
      step(0, k[1], k1[1], 0);
      chk_i($sformatf("en0 k%0d state", k), int'(bus.state), 0);
      chk_r($sformatf("en0 k%0d iout", k),  bus.i, 0.0, 1e-15);
    end
    chk_i("en0 up_cnt", int'(bus.up_cnt), m_ucnt);
    chk_i("en0 dn_cnt", int'(bus.dn_cnt), m_dcnt);
    step(0, 0, 0, 1);
    chk_i("clr up_cnt", int'(bus.up_cnt), 0);
    chk_i("clr dn_cnt", int'(bus.dn_cnt), 0);
    chk_r("clr q_acc",  bus.q_acc, 0.0, 1e-25);

    // Random requests on a capacitive node, checked against the model
    rst_n = 1'b0;
    m_reset();
    release_reset();
    bus.v = 0.6;
    cap_on = 1'b1;
    cu = 0; cd = 0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0) cu = ~cu;
      if ($urandom_range(0, 2) == 0) cd = ~cd;
      step(($urandom_range(0, 9) != 0), cu, cd, ($urandom_range(0, 49) == 0));
      chk_all($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cp_drv.md
Name: cp_drv

Overview:
- Clocked charge-pump driver: converts PFD-style UP/DN digital requests into a current source on an EEnet analog node.
- Sits between the phase-frequency detector and the loop-filter capacitor network of the CDR.
- It is the current-sourcing end of the capacitor interface. The capacitor measures node voltage and returns current. This block reads node voltage for compliance and drives current.
- Adds dead-zone filtering, compliance saturation with hysteresis, and a delivered-charge accumulator for the verification monitors.

Parameters:
- ICP, 100e-6, nominal pump current magnitude (A).
- MISMATCH, 0.0, fractional DN current error; DN current = ICP*(1+MISMATCH).
- ROUT, 1e6, output resistance driven on the EEnet (ohm); must be > 0.
- DZ, 1, consecutive sampled-high cycles required before current is applied (dead zone); range 0..255.
- VMAX, 1.1, upper compliance voltage (V).
- VMIN, 0.1, lower compliance voltage (V).
- VHYS, 0.02, release hysteresis for saturation (V).

Ports:
- clk      input   1      sampling clock; all state updates on posedge.
- rst_n    input   1      asynchronous active-low reset.
- en       input   1      pump enable; 0 forces zero current.
- up       input   1      charge request from PFD.
- dn       input   1      discharge request from PFD.
- clr_q    input   1      synchronous clear of q_acc and pulse counters.
- OUT      inout   EEnet  analog output node; block drives '{`wrealZState, Iout, ROUT}.
- sat_hi   output  1      upper compliance saturation active.
- sat_lo   output  1      lower compliance saturation active.
- state    output  3      FSM state encoding.
- up_cnt   output  16     count of qualified UP pulses.
- dn_cnt   output  16     count of qualified DN pulses.
- q_acc    output  real   net charge delivered to OUT since reset/clear (C).

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, immediate, no clock needed):
  - Iout=0, state=IDLE, sat_hi=0, sat_lo=0.
  - up_cnt=0, dn_cnt=0, q_acc=0.0.
  - Dead-zone counters cleared.
  - Reset mid-pulse drops current in the same timestep.
- up/dn are sampled at posedge clk. Iout is registered: it changes at the posedge that decides the new state (1-cycle latency from the sampled request).
- Dead zone: separate 8-bit counters up_hold and dn_hold.
  - Each increments (saturating at 255) while its sampled input is 1 and clears when it is 0.
  - A request is qualified when hold >= DZ. DZ=0 means qualified in the sampling cycle.
- FSM states: IDLE=0, PUMP_UP=1, PUMP_DN=2, BOTH=3, SAT=4.
  - IDLE: Iout=0.
  - PUMP_UP: Iout=+ICP.
  - PUMP_DN: Iout=-ICP*(1+MISMATCH).
  - BOTH: Iout=ICP - ICP*(1+MISMATCH), i.e. the mismatch residual.
  - SAT: Iout=0.
- Next state is chosen from qualified (uq, dq) and en:
  - en=0 -> IDLE.
  - uq&dq -> BOTH; uq -> PUMP_UP; dq -> PUMP_DN; neither -> IDLE.
  - Saturation overrides.
- Compliance is evaluated at each posedge using OUT.V:
  - OUT.V >= VMAX and next state would source positive current -> SAT, sat_hi=1.
  - OUT.V <= VMIN and next state would sink -> SAT, sat_lo=1.
  - sat_hi clears only when OUT.V < VMAX-VHYS. sat_lo clears only when OUT.V > VMIN+VHYS.
  - While a flag is set, current in that direction is blocked; the opposite direction is still allowed.
  - SAT is reported only when the requested current is fully blocked.
- Counters: up_cnt increments once per rising edge of uq (qualification onset); dn_cnt likewise for dq. Both wrap 0xFFFF -> 0.
- Charge accumulation: at each posedge, q_acc += Iout_prev*($realtime - t_prev).
  - Iout_prev is the current driven during the elapsed interval. t_prev is the previous posedge time, in seconds (timescale-converted).
  - The first posedge after reset adds nothing.
- clr_q=1 at a posedge zeroes q_acc and both counters; the interval ending at that edge is discarded. The FSM is unaffected.
- Simultaneous UP and DN rising in the same sample -> BOTH directly; both counters increment.
- ICP=0 is legal: the FSM runs and q_acc stays 0.

Test Plan:
- Reset mid-pump: UP held, then rst_n low mid-cycle -> OUT.I=0 in that timestep; counters=0, q_acc=0, state=0.
- Single UP pulse, DZ=1, clk 1ns, ICP=100uA, 5 cycles high -> state=1 one edge after qualification; Iout=+100e-6; up_cnt=1; q_acc≈5e-13 C (±1 cycle).
- DZ=3, UP pulses of 2 cycles repeated 10 times -> never qualified; Iout stays 0, up_cnt=0, q_acc=0.
- UP and DN both high 4 cycles, MISMATCH=0.05 -> state=3, Iout=-5e-6, q_acc≈-2e-14 C; up_cnt=dn_cnt=1.
- External cap 1pF, UP held from OUT.V=1.0V -> sat_hi at OUT.V>=1.1V, state=4, Iout=0. Apply DN -> state=2 (sink allowed). sat_hi clears once OUT.V<1.08V.
- en=0 with UP/DN toggling 20 cycles -> Iout=0, state=0, counters still count qualified pulses; clr_q pulse -> up_cnt=dn_cnt=0, q_acc=0.
